// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO side encodings and pointer sizing helpers
package fifo_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers and occupancy carry one extra wrap bit so full and empty differ
    function automatic int fifo_level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/gray2binary.sv
// rtl/gray2binary.sv - combinational gray-code to binary converter
module gray2binary #(
    parameter int BIN_WIDTH = 4
) (
    input  logic [BIN_WIDTH-1:0] gray,
    output logic [BIN_WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[BIN_WIDTH-1] = gray[BIN_WIDTH-1];
        for (int i = BIN_WIDTH - 2; i >= 0; i--) begin
            bin[i] = gray[i] ^ bin[i+1];
        end
    end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// rtl/gray_ptr_ctrl.sv - one side of an async FIFO: local pointer, remote sync, full/empty and level
module gray_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_inc,
    input  logic [ADDR_WIDTH:0]   i_remote_gray,
    output logic                  o_accept,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ADDR_WIDTH:0]   o_bin_ptr,
    output logic [ADDR_WIDTH:0]   o_gray_ptr,
    output logic                  o_flag,
    output logic                  o_almost,
    output logic [ADDR_WIDTH:0]   o_level
);

    localparam int PTR_W = fifo_level_width(ADDR_WIDTH);
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] FULL_ALMOST_LVL  = PTR_W'(DEPTH - ALMOST_TH);
    localparam logic [PTR_W-1:0] EMPTY_ALMOST_LVL = PTR_W'(ALMOST_TH);
    // A read side comes out of reset empty, so its flags start asserted
    localparam logic FLAG_RST = (MODE == MODE_RD);

    logic [PTR_W-1:0] sync_q [SYNC_STAGES];
    logic [PTR_W-1:0] rsync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] bin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] full_match;
    logic [PTR_W-1:0] level_next;
    logic             flag_next;
    logic             almost_next;

    assign o_accept = i_inc & ~o_flag & ~i_rst;
    assign o_addr   = o_bin_ptr[ADDR_WIDTH-1:0];
    assign rsync    = sync_q[SYNC_STAGES-1];

    // Plain flop chain: nothing may sit between stages of a crossing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= i_remote_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    gray2binary #(
        .BIN_WIDTH(PTR_W)
    ) u_gray2binary (
        .gray(rsync),
        .bin (rbin)
    );

    always_comb begin
        bin_next   = o_bin_ptr + PTR_W'(o_accept);
        gray_next  = bin_next ^ (bin_next >> 1);
        // Full when the writer is exactly one lap ahead: top two gray bits flip
        full_match = {~rsync[ADDR_WIDTH:ADDR_WIDTH-1], rsync[ADDR_WIDTH-2:0]};
        if (MODE == MODE_WR) begin
            flag_next   = (gray_next == full_match);
            level_next  = bin_next - rbin;
            almost_next = (level_next >= FULL_ALMOST_LVL);
        end else begin
            flag_next   = (gray_next == rsync);
            level_next  = rbin - bin_next;
            almost_next = (level_next <= EMPTY_ALMOST_LVL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bin_ptr  <= '0;
            o_gray_ptr <= '0;
            o_level    <= '0;
            o_flag     <= FLAG_RST;
            o_almost   <= FLAG_RST;
        end else begin
            o_bin_ptr  <= bin_next;
            o_gray_ptr <= gray_next;
            o_level    <= level_next;
            o_flag     <= flag_next;
            o_almost   <= almost_next;
        end
    end

endmodule

// File: doc/gray_ptr_ctrl.md
GRAY_PTR_CTRL -- requirements
Module: gray_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning address bits; DEPTH = 2^ADDR_WIDTH; legal values >= 2.
REQ-002 SHALL have parameter MODE, default 0, meaning 0 = write side (full flag), 1 = read side (empty flag).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning flops on remote pointer; legal values >= 2.
REQ-004 SHALL have parameter ALMOST_TH, default 2, meaning almost-flag threshold; legal range 1..DEPTH-1.
REQ-005 SHALL have port i_clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_inc, input, 1 bit: push request (MODE 0) or pop request (MODE 1).
REQ-008 SHALL have port i_remote_gray, input, ADDR_WIDTH+1 bits: opposite-side gray pointer, asynchronous to i_clk.
REQ-009 SHALL have port o_accept, output, 1 bit: combinational, = i_inc & ~o_flag & ~i_rst.
REQ-010 SHALL have port o_addr, output, ADDR_WIDTH bits: RAM address, = o_bin_ptr[ADDR_WIDTH-1:0].
REQ-011 SHALL have port o_bin_ptr, output, ADDR_WIDTH+1 bits: local binary pointer including wrap bit.
REQ-012 SHALL have port o_gray_ptr, output, ADDR_WIDTH+1 bits: registered gray of o_bin_ptr, for export to the other domain.
REQ-013 SHALL have port o_flag, output, 1 bit: full (MODE 0) or empty (MODE 1), registered.
REQ-014 SHALL have port o_almost, output, 1 bit: almost-full or almost-empty, registered.
REQ-015 SHALL have port o_level, output, ADDR_WIDTH+1 bits: occupancy 0..DEPTH, registered.

Function
REQ-016 SHALL, on each o_accept, compute bin_next = o_bin_ptr+1 modulo 2^(ADDR_WIDTH+1); otherwise bin_next = o_bin_ptr.
REQ-017 SHALL register o_bin_ptr <= bin_next and o_gray_ptr <= bin_next ^ (bin_next >> 1) on the same edge; the two never disagree.
REQ-018 SHALL pass i_remote_gray through SYNC_STAGES flops to give rsync; there is no other logic between those stages.
REQ-019 SHALL convert rsync to binary rbin combinationally: MSB copied, each lower bit = its gray bit XOR the next-higher binary bit.
REQ-020 SHALL, in MODE 0, register o_flag <= (gray_next == {~rsync[AW:AW-1], rsync[AW-2:0]}) and level_next = bin_next - rbin.
REQ-021 SHALL, in MODE 1, register o_flag <= (gray_next == rsync) and level_next = rbin - bin_next.
REQ-022 SHALL compute level_next modulo 2^(ADDR_WIDTH+1) and register it into o_level.
REQ-023 SHALL register o_almost <= (level_next >= DEPTH-ALMOST_TH) in MODE 0 and <= (level_next <= ALMOST_TH) in MODE 1.
REQ-024 SHALL give latency: local accept reaches o_flag, o_level and o_almost on the next edge; remote pointer change reaches them SYNC_STAGES+1 edges later.
REQ-025 SHALL be conservative: an i_inc with o_flag=1 is dropped, and the pointer never over-runs.
REQ-026 SHALL, on a simultaneous local accept and remote change, use the new local pointer and the currently synchronised remote value; the remote change is accounted later.
REQ-027 SHALL wrap the pointer from all-ones to zero with a single gray-bit change.

Reset
REQ-028 SHALL clear the pointers and all sync flops to 0 while i_rst is high; i_rst overrides i_inc.
REQ-029 SHALL set o_level to 0 on reset.
REQ-030 SHALL reset MODE 0 flags to o_flag=0 and o_almost=0.
REQ-031 SHALL reset MODE 1 flags to o_flag=1 and o_almost=1.
REQ-032 SHALL allow reset mid-operation and return to these values on the next edge.

Structure
REQ-033 SHALL place the MODE_WR/MODE_RD encodings and the DEPTH/level-width helper constants in shared package fifo_pkg.
REQ-034 SHALL instantiate the existing gray2binary module with BIN_WIDTH = ADDR_WIDTH+1 as its single sub-module for REQ-019.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2, ALMOST_TH=2)
REQ-035 SHALL cover MODE 0 fill: remote=0, 8 consecutive i_inc -> 8 accepts, o_almost=1 after the 6th edge, o_flag=1 and o_level=8 after the 8th, o_gray_ptr=4'b1100; 9th i_inc -> o_accept=0, pointer unchanged.
REQ-036 SHALL cover MODE 1 empty: remote=0 -> o_flag=1 and i_inc not accepted; remote set to 4'b0011 -> o_flag=0 and o_level=2 three edges later; 2 pops -> o_flag=1, o_bin_ptr=2.
REQ-037 SHALL cover wrap: MODE 0, remote tracks local, 16 accepts -> o_bin_ptr goes 4'b1111 then 4'b0000, and o_gray_ptr goes 4'b1000 then 4'b0000.
REQ-038 SHALL cover reset mid-op: 5 writes, then i_rst for 1 cycle with i_inc=1 -> no accept, o_bin_ptr=0, o_level=0, o_flag=0.
REQ-039 SHALL cover full release: MODE 0 full at level 8, remote advances by 1 -> o_flag falls and o_level=7 exactly 3 edges later.
